spi_master_param: RTL



---
 rtl/spi_master_param.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/spi_master_param.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_param
// Purpose  : Parametrised SPI master; one {rw, addr, data} frame per request,
//            MSB first, with start/busy/done handshake and read capture.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_param #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 1
) (
  input  logic              FSM_Clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              SPI_CLK,
  output logic              SPI_EN,
  output logic              SPI_IN,
  input  logic              SPI_OUT
);

  localparam int c_frame_n = 1 + ADDR_W + DATA_W;
  localparam int c_bit_w   = $clog2(c_frame_n + 1);
  localparam int c_div_w   = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);

  localparam logic [c_div_w-1:0] c_div_last   = c_div_w'(CLK_DIV - 1);
  localparam logic [c_bit_w-1:0] c_bit_last   = c_bit_w'(c_frame_n - 1);
  localparam logic [c_bit_w-1:0] c_data_first = c_bit_w'(1 + ADDR_W);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_low  = 2'd1;
  localparam logic [1:0] c_st_high = 2'd2;
  localparam logic [1:0] c_st_tail = 2'd3;

  generate
    if (CLK_DIV < 1 || ADDR_W < 1 || DATA_W < 1) begin : g_bad_param
      $error("spi_master_param: CLK_DIV, ADDR_W and DATA_W must all be >= 1");
    end
  endgenerate

  logic [1:0]           r_state, w_state_nxt;
  logic [c_div_w-1:0]   r_div_cnt, w_div_nxt;
  logic [c_bit_w-1:0]   r_bit_cnt, w_bit_nxt;
  logic [c_frame_n-1:0] r_shift, w_shift_nxt;
  logic [DATA_W-1:0]    r_cap, w_cap_nxt;
  logic [DATA_W-1:0]    r_rdata, w_rdata_nxt;
  logic                 r_rw, w_rw_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_spi_clk, w_clk_nxt;
  logic                 r_spi_en, w_en_nxt;
  logic                 r_spi_in, w_in_nxt;

  logic w_div_end;
  logic w_last_bit;

  assign w_div_end  = (r_div_cnt == c_div_last);
  assign w_last_bit = (r_bit_cnt == c_bit_last);

  always_ff @(posedge FSM_Clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (start)     w_state_nxt = c_st_low;
      c_st_low:  if (w_div_end) w_state_nxt = c_st_high;
      c_st_high: if (w_div_end) w_state_nxt = w_last_bit ? c_st_tail : c_st_low;
      c_st_tail: if (w_div_end) w_state_nxt = c_st_idle;
      default:                  w_state_nxt = c_st_idle;
    endcase
  end

  // Next values for every registered output/datapath element; SPI_IN only
  // moves on the edge that drops SPI_CLK, so it is stable across the high phase.
  always_comb begin
    w_div_nxt   = r_div_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_cap_nxt   = r_cap;
    w_rdata_nxt = r_rdata;
    w_rw_nxt    = r_rw;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_clk_nxt   = r_spi_clk;
    w_en_nxt    = r_spi_en;
    w_in_nxt    = r_spi_in;
    case (r_state)
      c_st_idle: begin
        w_busy_nxt = 1'b0;
        w_en_nxt   = 1'b0;
        w_clk_nxt  = 1'b0;
        w_in_nxt   = 1'b0;
        if (start) begin
          w_rw_nxt    = rw;
          w_shift_nxt = {rw, addr, (rw ? wdata : {DATA_W{1'b0}})};
          w_div_nxt   = '0;
          w_bit_nxt   = '0;
          w_cap_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_en_nxt    = 1'b1;
          w_in_nxt    = rw;
        end
      end
      c_st_low: begin
        w_div_nxt = w_div_end ? '0 : r_div_cnt + 1'b1;
        if (w_div_end) begin
          w_clk_nxt = 1'b1;
          if (!r_rw && (r_bit_cnt >= c_data_first)) begin
            w_cap_nxt = (r_cap << 1) | DATA_W'(SPI_OUT);
          end
        end
      end
      c_st_high: begin
        w_div_nxt = w_div_end ? '0 : r_div_cnt + 1'b1;
        if (w_div_end) begin
          w_clk_nxt = 1'b0;
          if (!w_last_bit) begin
            w_in_nxt    = r_shift[c_frame_n-2];
            w_shift_nxt = r_shift << 1;
            w_bit_nxt   = r_bit_cnt + 1'b1;
          end
        end
      end
      c_st_tail: begin
        w_div_nxt = w_div_end ? '0 : r_div_cnt + 1'b1;
        if (w_div_end) begin
          w_en_nxt   = 1'b0;
          w_in_nxt   = 1'b0;
          w_busy_nxt = 1'b0;
          w_done_nxt = 1'b1;
          if (!r_rw) w_rdata_nxt = r_cap;
        end
      end
      default: begin
        w_div_nxt  = '0;
        w_bit_nxt  = '0;
        w_busy_nxt = 1'b0;
        w_en_nxt   = 1'b0;
        w_clk_nxt  = 1'b0;
        w_in_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge FSM_Clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_cap     <= '0;
      r_rdata   <= '0;
      r_rw      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_spi_clk <= 1'b0;
      r_spi_en  <= 1'b0;
      r_spi_in  <= 1'b0;
    end else begin
      r_div_cnt <= w_div_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_cap     <= w_cap_nxt;
      r_rdata   <= w_rdata_nxt;
      r_rw      <= w_rw_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_spi_clk <= w_clk_nxt;
      r_spi_en  <= w_en_nxt;
      r_spi_in  <= w_in_nxt;
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign rdata   = r_rdata;
  assign SPI_CLK = r_spi_clk;
  assign SPI_EN  = r_spi_en;
  assign SPI_IN  = r_spi_in;

endmodule
`default_nettype wire
